// File: rtl/rr_hold_arbiter_if.sv
// Request/grant bundle between requesters and rr_hold_arbiter.
// The lock signal exists only when ARB_LOCK_EN is defined.
interface rr_hold_arbiter_if #(
  parameter int N    = 8,
  parameter int ID_W = $clog2(N)
);
  logic [N-1:0]    req;
`ifdef ARB_LOCK_EN
  logic            lock;
`endif
  logic [N-1:0]    grant;
  logic            grant_valid;
  logic [ID_W-1:0] grant_id;
  logic            expire;

`ifdef ARB_LOCK_EN
  modport slave  (input  req, lock, output grant, grant_valid, grant_id, expire);
  modport master (output req, lock, input  grant, grant_valid, grant_id, expire);
`else
  modport slave  (input  req,       output grant, grant_valid, grant_id, expire);
  modport master (output req,       input  grant, grant_valid, grant_id, expire);
`endif
endinterface

// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with hold-while-requesting, bounded tenure and a one-cycle handover gap.
// Optional ARB_LOCK_EN adds a lock input that suspends the hold limit for the current owner.
//
// state | meaning
// IDLE  | no owner, arbitrate on any request
// BUSY  | owner grant_id_q holds the resource, hold_cnt_q counts its tenure
// GAP   | one all-zero cycle after a release, then arbitrate again
module rr_hold_arbiter #(
  parameter  int N        = 8,
  parameter  int MAX_HOLD = 16,
  localparam int ID_W     = $clog2(N),
  localparam int CNT_W    = $clog2(MAX_HOLD)
) (
  input logic                clk,
  input logic                rst_n,
  rr_hold_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [ID_W-1:0]  PTR_INIT = ID_W'(N - 1);

  state_e           state_q,    state_d;
  logic [N-1:0]     grant_q,    grant_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic             expire_q,   expire_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [ID_W-1:0]  ptr_q,      ptr_d;

  logic             pick_found;
  logic [ID_W-1:0]  pick_idx;
  logic             own_req;
  logic             others_req;
  logic             at_limit;
  logic             lock_act;

`ifdef ARB_LOCK_EN
  assign lock_act = bus.lock;
`else
  assign lock_act = 1'b0;
`endif

  // Search starts just after the last owner, so the last owner ranks lowest.
  always_comb begin
    int idx;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!pick_found && bus.req[idx]) begin
        pick_found = 1'b1;
        pick_idx   = ID_W'(idx);
      end
    end
  end

  assign own_req    = bus.req[grant_id_q];
  assign others_req = |(bus.req & ~grant_q);
  assign at_limit   = (hold_cnt_q == CNT_LAST);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    expire_d   = 1'b0;
    hold_cnt_d = hold_cnt_q;
    ptr_d      = ptr_q;

    unique case (state_q)
      IDLE, GAP: begin
        grant_d = '0;
        if (pick_found) begin
          grant_d[pick_idx] = 1'b1;
          grant_id_d        = pick_idx;
          hold_cnt_d        = '0;
          state_d           = BUSY;
        end else begin
          state_d = IDLE;
        end
      end

      BUSY: begin
        if (!own_req) begin
          grant_d = '0;
          ptr_d   = grant_id_q;
          state_d = GAP;
        end else if (lock_act) begin
          if (!at_limit) hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end else if (at_limit && others_req) begin
          grant_d  = '0;
          ptr_d    = grant_id_q;
          expire_d = 1'b1;
          state_d  = GAP;
        end else if (at_limit) begin
          // Nobody else is waiting: start a fresh tenure instead of forcing a gap.
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      expire_q   <= 1'b0;
      hold_cnt_q <= '0;
      ptr_q      <= PTR_INIT;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      expire_q   <= expire_d;
      hold_cnt_q <= hold_cnt_d;
      ptr_q      <= ptr_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = |grant_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.expire      = expire_q;

endmodule
